// File: rtl/rv32imf_instr_prefetcher.sv
// Word-aligned OBI instruction prefetcher: credit-limited request FSM, outstanding/discard
// tracking, and a DEPTH-entry FIFO with an empty-FIFO bypass; branches flush buffered words.
module rv32imf_instr_prefetcher #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  localparam logic [1:0] IDLE           = 2'd0;
  localparam logic [1:0] WAIT_GNT       = 2'd1;
  localparam logic [1:0] WAIT_GNT_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   hold_q, hold_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic [31:0]   tgt;
  logic [CW-1:0] cnt_eff;
  logic [CW:0]   used;
  logic          has_credit;
  logic          gnt_fire;
  logic          stale_gnt;
  logic          resp_live;
  logic          pop;
  logic          push;
  logic          bypass;
  logic          unused_ok;

  assign unused_ok  = instr_err_i ^ branch_addr_i[1] ^ branch_addr_i[0];
  assign tgt        = {branch_addr_i[31:2], 2'b00};
  // A branch flushes the FIFO this cycle, so its words do not consume credit.
  assign cnt_eff    = branch_i ? '0 : cnt_q;
  assign used       = {1'b0, outst_q} + {1'b0, cnt_eff};
  assign has_credit = used < DEPTH_W;
  assign gnt_fire   = instr_req_o & instr_gnt_i;

  // hold_q keeps the address of an ungranted request stable while addr_q may
  // already hold a newer branch target.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    instr_req_o  = 1'b0;
    instr_addr_o = addr_q;
    stale_gnt    = 1'b0;
    case (state_q)
      IDLE: begin
        instr_addr_o = branch_i ? tgt : addr_q;
        instr_req_o  = (req_i | branch_i) & has_credit;
        if (branch_i) addr_d = tgt;
        if (instr_req_o) begin
          if (instr_gnt_i) begin
            addr_d = instr_addr_o + 32'd4;
          end else begin
            hold_d  = instr_addr_o;
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = hold_q;
        if (branch_i) begin
          addr_d = tgt;
          if (instr_gnt_i) begin
            stale_gnt = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = WAIT_GNT_FLUSH;
          end
        end else if (instr_gnt_i) begin
          addr_d  = hold_q + 32'd4;
          state_d = IDLE;
        end
      end
      WAIT_GNT_FLUSH: begin
        instr_req_o  = 1'b1;
        instr_addr_o = hold_q;
        if (branch_i) addr_d = tgt;
        if (instr_gnt_i) begin
          stale_gnt = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_live = instr_rvalid_i & (discard_q == '0);
  assign pop       = ~branch_i & (cnt_q != '0) & fetch_ready_i;
  assign bypass    = ~branch_i & resp_live & (cnt_q == '0) & fetch_ready_i;
  assign push      = ~branch_i & resp_live & ~bypass;

  always_comb begin
    outst_d = outst_q;
    if (gnt_fire && !instr_rvalid_i) outst_d = outst_q + ONE_C;
    else if (!gnt_fire && instr_rvalid_i) outst_d = outst_q - ONE_C;
  end

  // On a branch every still-outstanding response is stale, except one arriving now,
  // which is dropped directly.
  always_comb begin
    if (branch_i) discard_d = instr_rvalid_i ? outst_q - ONE_C : outst_q;
    else if (instr_rvalid_i && discard_q != '0) discard_d = discard_q - ONE_C;
    else discard_d = discard_q;
    if (stale_gnt) discard_d = discard_d + ONE_C;
  end

  always_comb begin
    cnt_d  = cnt_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (branch_i) begin
      cnt_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = instr_rdata_i;
        wptr_d        = wptr_q + ONE_P;
      end
      if (pop) rptr_d = rptr_q + ONE_P;
      if (push && !pop) cnt_d = cnt_q + ONE_C;
      else if (pop && !push) cnt_d = cnt_q - ONE_C;
    end
  end

  assign fetch_valid_o = ~branch_i & ((cnt_q != '0) | resp_live);
  assign fetch_rdata_o = (cnt_q != '0) ? mem_q[rptr_q] : instr_rdata_i;
  assign busy_o        = instr_req_o | (outst_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hold_q    <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      cnt_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Credit accounting makes a push into a full FIFO unreachable.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == DEPTH_C));

endmodule

// File: tb/tb_rv32imf_instr_prefetcher.sv
// Directed bench for rv32imf_instr_prefetcher (DEPTH=2) with an in-order memory responder
// whose read data is a fixed function of the word address.
module tb_rv32imf_instr_prefetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        fetch_ready_i = 1'b0;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        busy_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_grants = 0;
  int unsigned g0;
  logic        rsp_en = 1'b1;
  logic [31:0] pend[$];

  always #5 clk = ~clk;

  rv32imf_instr_prefetcher #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hAAAA_1001;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_in(input logic rq, input logic br, input logic [31:0] ba,
                        input logic rdy, input logic g);
    req_i         = rq;
    branch_i      = br;
    branch_addr_i = ba;
    fetch_ready_i = rdy;
    instr_gnt_i   = g;
    #1;
  endtask

  // Records grants before the edge; serves the oldest pending read one cycle later.
  task automatic tick();
    @(negedge clk);
    if (instr_req_o && instr_gnt_i) begin
      pend.push_back(instr_addr_o);
      n_grants++;
    end
    @(posedge clk);
    #1;
    if (rsp_en && pend.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mdata(pend.pop_front());
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (!busy_o && !fetch_valid_o) done = 1'b1;
      else tick();
    end
    check_eq("drain_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    check_eq("rst_req",   32'(instr_req_o),   32'd0);
    check_eq("rst_addr",  instr_addr_o,       32'h0);
    check_eq("rst_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("rst_rdata", fetch_rdata_o,      32'h0);
    check_eq("rst_busy",  32'(busy_o),        32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Boot branch with immediate grant, bypass on the next cycle
    set_in(1'b1, 1'b1, 32'h0000_1002, 1'b1, 1'b1);
    check_eq("boot_addr",  instr_addr_o,       32'h0000_1000);
    check_eq("boot_req",   32'(instr_req_o),   32'd1);
    check_eq("boot_valid0",32'(fetch_valid_o), 32'd0);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("boot_addr1", instr_addr_o,       32'h0000_1004);
    check_eq("boot_valid1",32'(fetch_valid_o), 32'd1);
    check_eq("boot_data1", fetch_rdata_o,      32'hAAAA_0001);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("boot_addr2", instr_addr_o,       32'h0000_1008);
    check_eq("boot_data2", fetch_rdata_o,      32'hAAAA_0005);
    tick();
    drain();

    // Backpressure: ready low for 6 cycles
    g0 = n_grants;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, (i == 0), 32'h0000_4000, 1'b0, 1'b1);
      if (i == 1) begin
        check_eq("bp_valid", 32'(fetch_valid_o), 32'd1);
        check_eq("bp_data0", fetch_rdata_o, mdata(32'h4000));
      end
      if (i == 5) begin
        check_eq("bp_req_off", 32'(instr_req_o), 32'd0);
        check_eq("bp_head",    fetch_rdata_o, mdata(32'h4000));
      end
      tick();
    end
    check_eq("bp_grants", 32'(n_grants - g0), 32'd2);
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bp_pop0",    fetch_rdata_o,    mdata(32'h4000));
    check_eq("bp_noreq",   32'(instr_req_o), 32'd0);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bp_pop1",    fetch_rdata_o,    mdata(32'h4004));
    check_eq("bp_resume",  instr_addr_o,     32'h0000_4008);
    check_eq("bp_resreq",  32'(instr_req_o), 32'd1);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bp_byp",     fetch_rdata_o,      mdata(32'h4008));
    check_eq("bp_bypv",    32'(fetch_valid_o), 32'd1);
    tick();
    drain();

    // Grant stall with a branch arriving mid-stall
    set_in(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b0);
    check_eq("st_addr0", instr_addr_o,     32'h0000_2000);
    check_eq("st_req0",  32'(instr_req_o), 32'd1);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("st_addr1", instr_addr_o, 32'h0000_2000);
    tick();
    set_in(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b0);
    check_eq("st_addr2", instr_addr_o,       32'h0000_2000);
    check_eq("st_valid2",32'(fetch_valid_o), 32'd0);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("st_addr3", instr_addr_o,     32'h0000_2000);
    check_eq("st_req3",  32'(instr_req_o), 32'd1);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("st_drop",  32'(fetch_valid_o), 32'd0);
    check_eq("st_tgt",   instr_addr_o,       32'h0000_3000);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("st_valid5",32'(fetch_valid_o), 32'd1);
    check_eq("st_data5", fetch_rdata_o,      mdata(32'h3000));
    tick();
    drain();

    // Branch with two responses outstanding
    rsp_en = 1'b0;
    set_in(1'b1, 1'b1, 32'h0000_5000, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 1'b1, 32'h0000_6000, 1'b1, 1'b1);
    check_eq("bo_req",   32'(instr_req_o),   32'd0);
    check_eq("bo_busy",  32'(busy_o),        32'd1);
    check_eq("bo_valid", 32'(fetch_valid_o), 32'd0);
    rsp_en = 1'b1;
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bo_drop0", 32'(fetch_valid_o), 32'd0);
    check_eq("bo_req3",  32'(instr_req_o),   32'd0);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bo_drop1", 32'(fetch_valid_o), 32'd0);
    check_eq("bo_tgt",   instr_addr_o,       32'h0000_6000);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bo_valid5",32'(fetch_valid_o), 32'd1);
    check_eq("bo_data5", fetch_rdata_o,      mdata(32'h6000));
    tick();
    drain();

    // Branch with one FIFO word and one response outstanding
    set_in(1'b1, 1'b1, 32'h0000_7000, 1'b0, 1'b1);
    tick();
    rsp_en = 1'b0;
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 1'b1, 32'h0000_8000, 1'b0, 1'b1);
    check_eq("bf_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("bf_addr",  instr_addr_o,       32'h0000_8000);
    rsp_en = 1'b1;
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bf_drop",  32'(fetch_valid_o), 32'd0);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("bf_valid4",32'(fetch_valid_o), 32'd1);
    check_eq("bf_data4", fetch_rdata_o,      mdata(32'h8000));
    tick();
    drain();

    // Address wrap-around
    set_in(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    check_eq("wr_addr0", instr_addr_o, 32'hFFFF_FFFC);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("wr_addr1", instr_addr_o,  32'h0000_0000);
    check_eq("wr_data",  fetch_rdata_o, mdata(32'hFFFF_FFFC));
    tick();
    drain();

    // Reset with one outstanding request and a buffered word
    set_in(1'b1, 1'b1, 32'h0000_9000, 1'b0, 1'b1);
    tick();
    rsp_en = 1'b0;
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("rs_busy_pre",  32'(busy_o),        32'd1);
    check_eq("rs_valid_pre", 32'(fetch_valid_o), 32'd1);
    rst_n          = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    pend.delete();
    rsp_en = 1'b1;
    #1;
    check_eq("rs_req",   32'(instr_req_o),   32'd0);
    check_eq("rs_addr",  instr_addr_o,       32'h0);
    check_eq("rs_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("rs_rdata", fetch_rdata_o,      32'h0);
    check_eq("rs_busy",  32'(busy_o),        32'd0);
    tick();
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("rs_post_busy",  32'(busy_o),        32'd0);
    check_eq("rs_post_valid", 32'(fetch_valid_o), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
